// File: rtl/decode_pkg.sv
// Shared decode constants, instruction field positions and the decoded-bundle type
// used by the decode stage and its register file.
package decode_pkg;

    localparam logic [5:0] LOAD       = 6'b010001;
    localparam logic [5:0] STORE0     = 6'b010000;
    localparam logic [5:0] STORE1     = 6'b010011;
    localparam logic [5:0] RTYPE      = 6'b000000;
    localparam logic [3:0] BRANCH_PFX = 4'b0011;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  dest;
        logic        we;
        logic        mem_read;
        logic        mem_write;
    } decode_bundle_t;

    // Dest and we here use the full 5-bit field; the stage narrows to REG_AW.
    function automatic decode_bundle_t decode(input logic [31:0] instr);
        decode_bundle_t b;
        logic [5:0]     op;
        logic           store;
        logic           branch;
        op          = instr[OPC_HI:OPC_LO];
        store       = (op == STORE0) || (op == STORE1);
        branch      = (op[5:2] == BRANCH_PFX);
        b.instr     = instr;
        b.dest      = (op == RTYPE) ? instr[RD_HI:RD_LO] : instr[RT_HI:RT_LO];
        b.mem_read  = (op == LOAD);
        b.mem_write = store;
        b.we        = !(store || branch || (instr == '0) || (b.dest == '0));
        return b;
    endfunction

endpackage

// File: rtl/rf_bypass.sv
// Two-read, one-write register file with r0 hardwired to zero and
// write-through bypass so a same-cycle write is visible to the readers.
module rf_bypass #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr0_i,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic              wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata0_o = mem_q[raddr0_i];
        rdata1_o = mem_q[raddr1_i];
        if (wr_en && (waddr_i == raddr0_i)) rdata0_o = wdata_i;
        if (wr_en && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
        if (raddr0_i == '0) rdata0_o = '0;
        if (raddr1_i == '0) rdata1_o = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes, reads operands, tracks in-flight destinations
// in a busy-bit scoreboard and holds a registered bundle for execute.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_we,
    output logic              out_mem_read,
    output logic              out_mem_write,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              sb_err
);

    decode_bundle_t    dec;
    decode_bundle_t    issue_b;
    decode_bundle_t    bundle_q;
    logic [4:0]        rs_f;
    logic [4:0]        rt_f;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic              dec_we;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_ret;
    logic [NREGS-1:0]  busy_d;
    logic              valid_q;
    logic              valid_d;
    logic              err_q;
    logic              err_d;
    logic              hazard;
    logic              accept;

    rf_bypass #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk_i    (clk),
        .rst_i    (rst),
        .we_i     (wb_valid & wb_we),
        .waddr_i  (wb_reg),
        .wdata_i  (wb_data),
        .raddr0_i (rs),
        .rdata0_o (rs_data),
        .raddr1_i (rt),
        .rdata1_o (rt_data)
    );

    always_comb begin
        dec          = decode(in_instr);
        rs_f         = in_instr[RS_HI:RS_LO];
        rt_f         = in_instr[RT_HI:RT_LO];
        rs           = rs_f[REG_AW-1:0];
        rt           = rt_f[REG_AW-1:0];
        dest         = dec.dest[REG_AW-1:0];
        dec_we       = dec.we && (dest != '0);
        issue_b      = dec;
        issue_b.dest = 5'(dest);
        issue_b.we   = dec_we;
        imm_ext      = DATA_W'(signed'(in_instr[IMM_HI:IMM_LO]));
    end

    // Hazards are evaluated against the scoreboard after this cycle's retire.
    always_comb begin
        busy_ret = busy_q;
        if (wb_valid) busy_ret[wb_reg] = 1'b0;
        hazard   = busy_ret[rs] || busy_ret[rt] || (dec_we && busy_ret[dest]);
        in_ready = !flush && !hazard && (!valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        busy_d = busy_ret;
        if (flush && valid_q && !out_ready && bundle_q.we) begin
            busy_d[bundle_q.dest[REG_AW-1:0]] = 1'b0;
        end
        if (accept && dec_we) busy_d[dest] = 1'b1;
        busy_d[0] = 1'b0;

        err_d = err_q || (wb_valid && (wb_reg != '0) && !busy_q[wb_reg]);

        valid_d = valid_q;
        if (flush)          valid_d = 1'b0;
        else if (accept)    valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            bundle_q  <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else begin
            busy_q  <= busy_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            if (accept) begin
                bundle_q  <= issue_b;
                rs_data_q <= rs_data;
                rt_data_q <= rt_data;
                imm_q     <= imm_ext;
            end
        end
    end

    assign out_valid     = valid_q;
    assign out_instr     = bundle_q.instr;
    assign out_rs_data   = rs_data_q;
    assign out_rt_data   = rt_data_q;
    assign out_imm       = imm_q;
    assign out_dest      = bundle_q.dest[REG_AW-1:0];
    assign out_we        = bundle_q.we;
    assign out_mem_read  = bundle_q.mem_read;
    assign out_mem_write = bundle_q.mem_write;
    assign sb_err        = err_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed bench for decode_stage against a behavioural model
// of decode, register file, scoreboard and output handshake.
module tb_decode_stage;

    localparam int DW = 32;
    localparam int NR = 32;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, out_ready, flush, wb_valid, wb_we;
    logic [31:0]   in_instr;
    logic [4:0]    wb_reg;
    logic [DW-1:0] wb_data;
    logic          in_ready, out_valid, out_we, out_mem_read, out_mem_write, sb_err;
    logic [31:0]   out_instr;
    logic [DW-1:0] out_rs_data, out_rt_data, out_imm;
    logic [4:0]    out_dest;

    decode_stage #(.DATA_W(DW), .NREGS(NR)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
        .out_dest(out_dest), .out_we(out_we), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .flush(flush), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_reg(wb_reg), .wb_data(wb_data), .sb_err(sb_err)
    );

    // Narrow configuration: 8 registers, 16-bit data.
    logic          s_in_valid, s_out_ready, s_in_ready, s_out_valid, s_out_we;
    logic          s_out_mr, s_out_mw, s_sb_err;
    logic [31:0]   s_in_instr, s_out_instr;
    logic [15:0]   s_rs_data, s_rt_data, s_imm;
    logic [2:0]    s_dest;
    logic          s_flush = 1'b0, s_wb_valid = 1'b0, s_wb_we = 1'b0;
    logic [2:0]    s_wb_reg = '0;
    logic [15:0]   s_wb_data = '0;

    decode_stage #(.DATA_W(16), .NREGS(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_instr(s_in_instr),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_instr(s_out_instr), .out_rs_data(s_rs_data), .out_rt_data(s_rt_data),
        .out_imm(s_imm), .out_dest(s_dest), .out_we(s_out_we), .out_mem_read(s_out_mr),
        .out_mem_write(s_out_mw), .flush(s_flush), .wb_valid(s_wb_valid), .wb_we(s_wb_we),
        .wb_reg(s_wb_reg), .wb_data(s_wb_data), .sb_err(s_sb_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state
    bit          m_busy [NR];
    logic [31:0] m_rf   [NR];
    bit          m_valid, m_we, m_mr, m_mw, m_err;
    logic [31:0] m_instr, m_rsd, m_rtd, m_imm;
    int          m_dest;
    int          pend[$];
    bit          chk_en = 1'b0;

    function automatic void ref_dec(input logic [31:0] ins, output int rs, output int rt,
                                    output int dest, output bit we, output bit mr,
                                    output bit mw, output logic [31:0] imm);
        int op;
        bit br;
        op   = int'(ins >> 26);
        rs   = int'((ins >> 21) & 32'd31) % NR;
        rt   = int'((ins >> 16) & 32'd31) % NR;
        dest = (op == 0) ? int'((ins >> 11) & 32'd31) % NR : rt;
        mr   = (op == 17);
        mw   = (op == 16) || (op == 19);
        br   = (op / 4 == 3);
        we   = !(mw || br || ins == 0 || dest == 0);
        imm  = ins & 32'hFFFF;
        if (ins[15]) imm = imm | 32'hFFFF_0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_busy[i] = 1'b0;
            m_rf[i]   = '0;
        end
        m_valid = 0; m_we = 0; m_mr = 0; m_mw = 0; m_err = 0;
        m_instr = '0; m_rsd = '0; m_rtd = '0; m_imm = '0; m_dest = 0;
        pend.delete();
    endtask

    // Inputs are applied before the call; compares, clocks once, advances the model.
    task automatic step();
        int          rs, rt, dest;
        bit          we, mr, mw, hz, rdy;
        logic [31:0] imm;
        bit          b [NR];
        #1;
        ref_dec(in_instr, rs, rt, dest, we, mr, mw, imm);
        b = m_busy;
        if (wb_valid) b[wb_reg] = 1'b0;
        hz  = b[rs] || b[rt] || (we && b[dest]);
        rdy = !flush && !hz && (!m_valid || out_ready);
        if (chk_en) begin
            check_eq("in_ready", in_ready, rdy);
            check_eq("out_valid", out_valid, m_valid);
            check_eq("sb_err", sb_err, m_err);
            check_eq("out_instr", out_instr, m_instr);
            check_eq("out_rs_data", out_rs_data, m_rsd);
            check_eq("out_rt_data", out_rt_data, m_rtd);
            check_eq("out_imm", out_imm, m_imm);
            check_eq("out_dest", out_dest, m_dest);
            check_eq("out_we", out_we, m_we);
            check_eq("out_mem_read", out_mem_read, m_mr);
            check_eq("out_mem_write", out_mem_write, m_mw);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (wb_valid && wb_reg != 0 && !m_busy[wb_reg]) m_err = 1'b1;
            if (wb_valid && wb_we && wb_reg != 0) m_rf[wb_reg] = wb_data;
            if (m_valid && out_ready && m_we) pend.push_back(m_dest);
            if (flush) begin
                if (m_valid && !out_ready && m_we) b[m_dest] = 1'b0;
                m_valid = 1'b0;
            end else if (in_valid && rdy) begin
                m_instr = in_instr; m_rsd = m_rf[rs]; m_rtd = m_rf[rt]; m_imm = imm;
                m_dest = dest; m_we = we; m_mr = mr; m_mw = mw; m_valid = 1'b1;
                if (we) b[dest] = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            m_busy = b;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; in_instr = '0; out_ready = 1; flush = 0;
        wb_valid = 0; wb_we = 0; wb_reg = '0; wb_data = '0;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op;
        case ($urandom_range(0, 7))
            0, 1:    op = 6'd0;
            2:       op = 6'b010001;
            3:       op = 6'b010000;
            4:       op = 6'b010011;
            5:       op = 6'(12 + $urandom_range(0, 3));
            default: op = 6'($urandom);
        endcase
        w        = $urandom;
        w[31:26] = op;
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        w[15:11] = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 31) == 0) w = '0;
        return w;
    endfunction

    initial begin
        idle();
        s_in_valid = 0; s_in_instr = '0; s_out_ready = 1;
        model_reset();
        rst = 1;
        step();
        step();
        rst = 0;
        chk_en = 1;

        // Reset state, then issue r3 <= r1 op r2
        step();
        in_valid = 1; in_instr = rtype(1, 2, 3); out_ready = 0;
        step();
        check_eq("issue_dest", out_dest, 3);
        check_eq("issue_we", out_we, 1);

        // RAW on r3, resolved by a same-cycle write-back
        in_instr = rtype(3, 0, 4); out_ready = 1;
        step();
        wb_valid = 1; wb_we = 1; wb_reg = 5'd3; wb_data = 32'hDEAD_BEEF;
        #1 check_eq("raw_unblock", in_ready, 1);
        step();
        in_valid = 0; wb_valid = 0;
        check_eq("raw_bypass", out_rs_data, 32'hDEAD_BEEF);
        step();

        // Back-pressure
        in_valid = 1; in_instr = rtype(1, 2, 10);
        step();
        out_ready = 0; in_instr = rtype(2, 1, 11);
        repeat (3) step();
        check_eq("bp_hold", out_instr, rtype(1, 2, 10));
        out_ready = 1;
        step();
        in_valid = 0;
        check_eq("bp_next", out_instr, rtype(2, 1, 11));
        step();

        // Flush of a held bundle writing r5 (load, dest = rt)
        in_valid = 1; in_instr = {6'b010001, 5'd1, 5'd5, 16'h8001}; out_ready = 0;
        step();
        check_eq("load_imm_sext", out_imm, 32'hFFFF_8001);
        in_valid = 0; flush = 1;
        step();
        flush = 0; in_valid = 1; in_instr = rtype(5, 0, 6);
        check_eq("flush_valid", out_valid, 0);
        #1 check_eq("flush_unstall", in_ready, 1);
        step();
        idle();
        step();

        // Narrow configuration: load with dest field 9 lands on r1
        s_in_valid = 1; s_in_instr = {6'b010001, 5'd0, 5'd9, 16'h8001}; s_out_ready = 0;
        step();
        s_in_valid = 0;
        check_eq("n8_valid", s_out_valid, 1);
        check_eq("n8_imm", s_imm, 16'h8001);
        check_eq("n8_mem_read", s_out_mr, 1);
        check_eq("n8_dest", s_dest, 1);
        check_eq("n8_we", s_out_we, 1);
        s_in_instr = rtype(9, 0, 0); s_out_ready = 1;
        #1 check_eq("n8_alias_hazard", s_in_ready, 0);
        step();

        // Random traffic with a well-behaved downstream that retires what it consumes
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_valid  = 0; wb_we = 0; wb_reg = '0; wb_data = $urandom;
            if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                int k;
                k        = $urandom_range(0, pend.size() - 1);
                wb_valid = 1;
                wb_we    = ($urandom_range(0, 3) != 0);
                wb_reg   = 5'(pend[k]);
                pend.delete(k);
            end
            step();
        end

        // Reset mid-operation wins over everything else
        rst = 1; in_valid = 1; in_instr = rtype(1, 2, 3); flush = 1; wb_valid = 1; wb_reg = 5'd4;
        step();
        idle();
        step();
        check_eq("rst_mid_valid", out_valid, 0);

        // Release, then stray retire raises the sticky error
        in_valid = 1; in_instr = {6'b010001, 5'd0, 5'd7, 16'h0010};
        step();
        in_valid = 0;
        step();
        wb_valid = 1; wb_we = 1; wb_reg = 5'd7; wb_data = 32'h1234_5678;
        step();
        wb_valid = 0; in_valid = 1;
        step();
        in_valid = 0;
        step();
        wb_valid = 1; wb_we = 0; wb_reg = 5'd7; wb_data = 32'hFFFF_FFFF;
        step();
        wb_valid = 0; in_valid = 1; in_instr = rtype(7, 0, 0);
        #1 check_eq("release_clears_busy", in_ready, 1);
        step();
        in_valid = 0;
        check_eq("release_keeps_r7", out_rs_data, 32'h1234_5678);
        check_eq("release_no_err", sb_err, 0);
        wb_valid = 1; wb_we = 0; wb_reg = 5'd7;
        step();
        wb_valid = 0;
        repeat (3) step();
        check_eq("err_sticky", sb_err, 1);
        rst = 1;
        step();
        rst = 0;
        step();
        check_eq("err_cleared", sb_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
